// File: rtl/uv_rst_ctrl.sv
// uv_rst_ctrl: multi-domain reset sequencer with clock-lock gating, button debounce and sticky reset cause.
// Optional macro UV_RST_CTRL_STAGGER_EN: release domains one every STAGE_GAP cycles instead of all at once.
module uv_rst_ctrl #(
  parameter int RST_NUM     = 4,
  parameter int DBNC_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int LOCK_WAIT   = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_rst_n,
  input  logic               clk_locked,
  input  logic               sw_rst_req,
  input  logic               wdt_rst_req,
  input  logic               cause_clr,
  output logic [RST_NUM-1:0] rst_out_n,
  output logic               rst_busy,
  output logic [3:0]         rst_cause
);

  localparam int DW = $clog2(DBNC_CYCLES) + 1;
  localparam int GW = $clog2(STAGE_GAP) + 1;
  localparam int LW = $clog2(LOCK_WAIT) + 1;

  localparam logic [DW-1:0] DBNC_MAX = DW'(DBNC_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE    = DW'(1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(STAGE_GAP - 1);
  localparam logic [GW-1:0] G_ONE    = GW'(1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_WAIT - 1);
  localparam logic [LW-1:0] L_ONE    = LW'(1);

`ifdef UV_RST_CTRL_STAGGER_EN
  localparam logic [RST_NUM-1:0] FIRST_MASK = RST_NUM'(1);
  localparam logic [RST_NUM-1:0] FIRST_REL  = FIRST_MASK;
`else
  localparam logic [RST_NUM-1:0] FIRST_REL  = '1;
`endif

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic          btn_meta_r;
  logic          btn_sync_r;
  logic          btn_stable_r;
  logic [DW-1:0] dbnc_cnt_r;

  logic [1:0]         state_r, state_s;
  logic [GW-1:0]      hold_cnt_r, hold_cnt_s;
  logic [LW-1:0]      lock_cnt_r, lock_cnt_s;
  logic [RST_NUM-1:0] rst_out_n_r, out_s;
  logic               busy_r, busy_s;
  logic [3:0]         cause_r, cause_s;
`ifdef UV_RST_CTRL_STAGGER_EN
  logic [GW-1:0]      gap_cnt_r, gap_cnt_s;
`endif

  logic       btn_fall_s;
  logic       lock_loss_s;
  logic       rst_event_s;
  logic [3:0] cause_set_s;

  // Button synchroniser and debouncer; stable level only moves after DBNC_CYCLES of disagreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_r   <= 1'b1;
      btn_sync_r   <= 1'b1;
      btn_stable_r <= 1'b1;
      dbnc_cnt_r   <= '0;
    end else begin
      btn_meta_r <= btn_rst_n;
      btn_sync_r <= btn_meta_r;
      if (btn_sync_r == btn_stable_r) begin
        dbnc_cnt_r <= '0;
      end else if (dbnc_cnt_r == DBNC_MAX) begin
        btn_stable_r <= btn_sync_r;
        dbnc_cnt_r   <= '0;
      end else begin
        dbnc_cnt_r <= dbnc_cnt_r + D_ONE;
      end
    end
  end

  // The button event fires on the very edge the stable level drops, so the restart lines up with it.
  assign btn_fall_s  = btn_stable_r & ~btn_sync_r & (dbnc_cnt_r == DBNC_MAX);
  assign lock_loss_s = ~clk_locked & ((state_r == ST_RELEASE) | (state_r == ST_RUN));
  assign cause_set_s = {lock_loss_s, wdt_rst_req, sw_rst_req, btn_fall_s};
  assign rst_event_s = |cause_set_s;

  // Sequencer next-state: HOLD -> WAIT_LOCK -> RELEASE -> RUN, any reset event restarts from HOLD.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    lock_cnt_s = lock_cnt_r;
    out_s      = rst_out_n_r;
`ifdef UV_RST_CTRL_STAGGER_EN
    gap_cnt_s  = gap_cnt_r;
`endif
    if (rst_event_s) begin
      state_s    = ST_HOLD;
      hold_cnt_s = '0;
      lock_cnt_s = '0;
      out_s      = '0;
`ifdef UV_RST_CTRL_STAGGER_EN
      gap_cnt_s  = '0;
`endif
    end else begin
      case (state_r)
        ST_HOLD: begin
          out_s = '0;
          if (hold_cnt_r != GAP_MAX) begin
            hold_cnt_s = hold_cnt_r + G_ONE;
          end else if (btn_stable_r) begin
            hold_cnt_s = '0;
            state_s    = ST_WAIT_LOCK;
          end else begin
            hold_cnt_s = hold_cnt_r;
          end
        end
        ST_WAIT_LOCK: begin
          if (!clk_locked) begin
            lock_cnt_s = '0;
          end else if (lock_cnt_r == LOCK_MAX) begin
            lock_cnt_s = '0;
            out_s      = FIRST_REL;
            state_s    = (&FIRST_REL) ? ST_RUN : ST_RELEASE;
          end else begin
            lock_cnt_s = lock_cnt_r + L_ONE;
          end
        end
        ST_RELEASE: begin
`ifdef UV_RST_CTRL_STAGGER_EN
          if (gap_cnt_r == GAP_MAX) begin
            gap_cnt_s = '0;
            out_s     = (rst_out_n_r << 1) | FIRST_MASK;
            if (&out_s) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            gap_cnt_s = gap_cnt_r + G_ONE;
          end
`else
          out_s   = '1;
          state_s = ST_RUN;
`endif
        end
        ST_RUN: begin
          out_s = '1;
        end
        default: begin
          state_s = ST_HOLD;
          out_s   = '0;
        end
      endcase
    end
    busy_s  = ~&out_s;
    cause_s = (cause_clr ? 4'b0000 : cause_r) | cause_set_s;
  end

  // Sequencer, output and cause registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= '0;
      lock_cnt_r  <= '0;
      rst_out_n_r <= '0;
      busy_r      <= 1'b1;
      cause_r     <= 4'b0000;
`ifdef UV_RST_CTRL_STAGGER_EN
      gap_cnt_r   <= '0;
`endif
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      lock_cnt_r  <= lock_cnt_s;
      rst_out_n_r <= out_s;
      busy_r      <= busy_s;
      cause_r     <= cause_s;
`ifdef UV_RST_CTRL_STAGGER_EN
      gap_cnt_r   <= gap_cnt_s;
`endif
    end
  end

  assign rst_out_n = rst_out_n_r;
  assign rst_busy  = busy_r;
  assign rst_cause = cause_r;

endmodule
